// File: rtl/sr_latch_bank.sv
// sr_latch_bank: a bank of WIDTH clocked set/reset bits.
// Each bit has a compile-time conflict policy, registered rise/fall pulses
// and a saturating rise counter. A sticky flag records set/clear collisions.
module sr_latch_bank #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 4,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clear,
  input  logic             cnt_clr,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [CNT_W-1:0] count,
  output logic             conflict
);

  typedef enum logic [1:0] {
    MODE_RST_DOM = 2'd0,
    MODE_SET_DOM = 2'd1,
    MODE_HOLD    = 2'd2,
    MODE_TOGGLE  = 2'd3
  } conflict_mode_e;

  // Any out-of-range MODE collapses to reset-dominant.
  localparam conflict_mode_e CMODE =
    (MODE >= 0 && MODE <= 3) ? conflict_mode_e'(MODE[1:0]) : MODE_RST_DOM;

  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;
  logic             collide;
  logic [CNT_W-1:0] cnt [WIDTH];

  // Per-bit next state from set/clear, resolving collisions by CMODE.
  always_comb begin
    next_q = q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case ({set[i], clear[i]})
        2'b10:   next_q[i] = 1'b1;
        2'b01:   next_q[i] = 1'b0;
        2'b11: begin
          case (CMODE)
            MODE_RST_DOM: next_q[i] = 1'b0;
            MODE_SET_DOM: next_q[i] = 1'b1;
            MODE_HOLD:    next_q[i] = q[i];
            MODE_TOGGLE:  next_q[i] = ~q[i];
            default:      next_q[i] = 1'b0;
          endcase
        end
        default: next_q[i] = q[i];
      endcase
    end
  end

  // Edge detection and collision detect derived from the pending update.
  always_comb begin
    rise_next = next_q & ~q;
    fall_next = ~next_q & q;
    collide   = |(set & clear);
  end

  // Storage bits and their one-cycle transition pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      q    <= next_q;
      rise <= rise_next;
      fall <= fall_next;
    end
  end

  // Saturating per-channel rise counters; cnt_clr takes priority over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (cnt_clr) begin
          cnt[i] <= '0;
        end else if (rise_next[i] && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Sticky collision flag; a new collision outranks a simultaneous cnt_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict <= 1'b0;
    end else if (collide) begin
      conflict <= 1'b1;
    end else if (cnt_clr) begin
      conflict <= 1'b0;
    end
  end

  // Counter readback mux; selects beyond the last channel read as zero.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (32'(sel) == i) begin
        count = cnt[i];
      end
    end
  end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Scoreboard bench for sr_latch_bank: four WIDTH=8 instances (MODE 0..3)
// and one WIDTH=6 instance share the same stimulus.
module tb_sr_latch_bank;

  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] set;
  logic [7:0] clear;
  logic       cnt_clr;
  logic [2:0] sel;

  logic [7:0] q_a     [NI];
  logic [7:0] rise_a  [NI];
  logic [7:0] fall_a  [NI];
  logic [3:0] count_a [NI];
  logic       conf_a  [NI];

  logic [5:0] q4, rise4, fall4;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    sr_latch_bank #(.WIDTH(8), .MODE(g), .CNT_W(4)) u_dut (
      .clk(clk), .reset(reset), .set(set), .clear(clear), .cnt_clr(cnt_clr),
      .sel(sel), .q(q_a[g]), .rise(rise_a[g]), .fall(fall_a[g]),
      .count(count_a[g]), .conflict(conf_a[g])
    );
  end

  sr_latch_bank #(.WIDTH(6), .MODE(0), .CNT_W(4)) u_dut6 (
    .clk(clk), .reset(reset), .set(set[5:0]), .clear(clear[5:0]), .cnt_clr(cnt_clr),
    .sel(sel), .q(q4), .rise(rise4), .fall(fall4),
    .count(count_a[4]), .conflict(conf_a[4])
  );

  assign q_a[4]    = {2'b00, q4};
  assign rise_a[4] = {2'b00, rise4};
  assign fall_a[4] = {2'b00, fall4};

  typedef struct packed {
    logic [NI-1:0][7:0] q;
    logic [NI-1:0][7:0] rise;
    logic [NI-1:0][7:0] fall;
    logic [NI-1:0][3:0] count;
    logic [NI-1:0]      conf;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference state: plain per-bit values and integer counters.
  bit [7:0] mq    [NI];
  int       mcnt  [NI][8];
  bit       mconf [NI];

  task automatic chk(input string name, input int m, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h expected %h at %0t", name, m, act, exp, $time);
    end
  endtask

  function automatic int inst_width(input int m);
    return (m == 4) ? 6 : 8;
  endfunction

  function automatic int inst_mode(input int m);
    return (m < 4) ? m : 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < NI; m++) begin
      mq[m] = '0;
      mconf[m] = 1'b0;
      for (int b = 0; b < 8; b++) mcnt[m][b] = 0;
    end
  endtask

  // Drive inputs for the coming edge and queue the state expected after it.
  task automatic apply(input logic [7:0] s, input logic [7:0] c, input logic cc, input logic [2:0] sl);
    exp_t e;
    bit [7:0] nq, r, f;
    bit hit;
    int w;
    e = '0;
    set = s; clear = c; cnt_clr = cc; sel = sl;
    for (int m = 0; m < NI; m++) begin
      w = inst_width(m);
      nq = mq[m]; r = '0; f = '0; hit = 1'b0;
      for (int b = 0; b < w; b++) begin
        if (s[b] && !c[b])      nq[b] = 1'b1;
        else if (c[b] && !s[b]) nq[b] = 1'b0;
        else if (s[b] && c[b]) begin
          hit = 1'b1;
          case (inst_mode(m))
            1:       nq[b] = 1'b1;
            2:       nq[b] = mq[m][b];
            3:       nq[b] = ~mq[m][b];
            default: nq[b] = 1'b0;
          endcase
        end
        r[b] = nq[b] & ~mq[m][b];
        f[b] = ~nq[b] & mq[m][b];
        if (cc)                         mcnt[m][b] = 0;
        else if (r[b] && mcnt[m][b] < 15) mcnt[m][b] = mcnt[m][b] + 1;
      end
      if (hit)     mconf[m] = 1'b1;
      else if (cc) mconf[m] = 1'b0;
      mq[m] = nq;
      e.q[m]     = nq;
      e.rise[m]  = r;
      e.fall[m]  = f;
      e.count[m] = (int'(sl) < w) ? 4'(mcnt[m][sl]) : 4'd0;
      e.conf[m]  = mconf[m];
    end
    sb.push_back(e);
  endtask

  task automatic step(input logic [7:0] s, input logic [7:0] c, input logic cc, input logic [2:0] sl);
    @(posedge clk);
    #2;
    apply(s, c, cc, sl);
  endtask

  task automatic check_all_zero(input string tag);
    for (int m = 0; m < NI; m++) begin
      chk({tag, "_q"}, m, q_a[m], 8'h00);
      chk({tag, "_rise"}, m, rise_a[m], 8'h00);
      chk({tag, "_fall"}, m, fall_a[m], 8'h00);
      chk({tag, "_count"}, m, {4'h0, count_a[m]}, 8'h00);
      chk({tag, "_conflict"}, m, {7'h0, conf_a[m]}, 8'h00);
    end
  endtask

  // Monitor: one result per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int m = 0; m < NI; m++) begin
          chk("q", m, q_a[m], e.q[m]);
          chk("rise", m, rise_a[m], e.rise[m]);
          chk("fall", m, fall_a[m], e.fall[m]);
          chk("count", m, {4'h0, count_a[m]}, {4'h0, e.count[m]});
          chk("conflict", m, {7'h0, conf_a[m]}, {7'h0, e.conf[m]});
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by a random phase.
  initial begin
    reset = 1'b1; set = '0; clear = '0; cnt_clr = 1'b0; sel = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    #2;
    reset = 1'b0;

    // Basic set / clear / hold.
    step(8'h05, 8'h00, 1'b0, 3'd0);
    step(8'h00, 8'h01, 1'b0, 3'd0);
    step(8'h00, 8'h00, 1'b0, 3'd2);
    step(8'h00, 8'h00, 1'b0, 3'd2);

    // Collision on bit 0 from q[0]=0, twice to expose toggling.
    step(8'h01, 8'h01, 1'b0, 3'd0);
    step(8'h01, 8'h01, 1'b0, 3'd0);

    // cnt_clr against a same-edge rise, then against a collision, then alone.
    step(8'h00, 8'h01, 1'b0, 3'd0);
    step(8'h01, 8'h00, 1'b1, 3'd0);
    step(8'h02, 8'h02, 1'b1, 3'd0);
    step(8'h00, 8'h00, 1'b1, 3'd0);

    // Saturation of channel 3.
    for (int k = 0; k < 20; k++) begin
      step(8'h08, 8'h00, 1'b0, 3'd3);
      step(8'h00, 8'h08, 1'b0, 3'd3);
    end
    step(8'h00, 8'h00, 1'b0, 3'd2);
    step(8'h00, 8'h00, 1'b0, 3'd7);

    // Build a busy state then reset between edges.
    step(8'hFF, 8'h00, 1'b0, 3'd3);
    step(8'h10, 8'h10, 1'b0, 3'd3);
    @(posedge clk);
    #2;
    reset = 1'b1; set = '0; clear = '0; cnt_clr = 1'b0;
    #1;
    check_all_zero("async_reset");
    #1;
    reset = 1'b0;
    model_reset();
    apply(8'h80, 8'h00, 1'b0, 3'd7);

    // Random phase.
    for (int k = 0; k < 300; k++) begin
      step(8'($urandom) & 8'($urandom),
           8'($urandom) & 8'($urandom) & 8'($urandom),
           ($urandom_range(0, 15) == 0),
           3'($urandom_range(0, 7)));
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drain", 0, 8'(sb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
